// File: rtl/seg_instruction_decode.sv
// Instruction-decode pipeline stage: register file with write-back bypass,
// control decode, branch/jump resolution, hazard stall detection and the
// ID/EX pipeline register.
// Optional feature macro: ID_DEBUG_READ_EN adds a combinational debug read
// port into the register file (i_debug_reg_addr / o_debug_reg_data).
module seg_instruction_decode #(
   parameter int LEN     = 32,
   parameter int NB_ADDR = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [LEN-1:0]     i_instruction,
   input  logic [LEN-1:0]     i_PC,
   input  logic               i_RegWrite,
   input  logic [NB_ADDR-1:0] i_write_reg,
   input  logic [LEN-1:0]     i_write_data,
   input  logic               i_mem_RegWrite,
   input  logic [NB_ADDR-1:0] i_mem_write_reg,
`ifdef ID_DEBUG_READ_EN
   input  logic [NB_ADDR-1:0] i_debug_reg_addr,
   output logic [LEN-1:0]     o_debug_reg_data,
`endif
   output logic               o_PCSrc,
   output logic [LEN-1:0]     o_PC_branch,
   output logic               o_jump,
   output logic [LEN-1:0]     o_PC_dir_jump,
   output logic               o_stall_flag,
   output logic [LEN-1:0]     o_PC,
   output logic [LEN-1:0]     o_read_data_1,
   output logic [LEN-1:0]     o_read_data_2,
   output logic [LEN-1:0]     o_sign_ext,
   output logic [NB_ADDR-1:0] o_rs,
   output logic [NB_ADDR-1:0] o_rt,
   output logic [NB_ADDR-1:0] o_rd,
   output logic [5:0]         o_opcode,
   output logic [5:0]         o_funct,
   output logic               o_RegWrite,
   output logic               o_MemRead,
   output logic               o_MemWrite,
   output logic               o_MemtoReg,
   output logic               o_RegDst,
   output logic               o_ALUSrc
);

   localparam int NREG = 2 ** NB_ADDR;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;

   // Control word order: {RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc}
   localparam logic [5:0] CTRL_R  = 6'b100010;
   localparam logic [5:0] CTRL_LW = 6'b110101;
   localparam logic [5:0] CTRL_SW = 6'b001001;
   localparam logic [5:0] CTRL_I  = 6'b100001;

   // Instruction fields
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic [NB_ADDR-1:0] rs;
   logic [NB_ADDR-1:0] rt;
   logic [NB_ADDR-1:0] rd;
   logic [15:0]        imm;
   logic               shamt_unused;

   assign opcode       = i_instruction[31:26];
   assign funct        = i_instruction[5:0];
   assign rs           = i_instruction[21 +: NB_ADDR];
   assign rt           = i_instruction[16 +: NB_ADDR];
   assign rd           = i_instruction[11 +: NB_ADDR];
   assign imm          = i_instruction[15:0];
   assign shamt_unused = ^i_instruction[10:6];

   // Register file; entry 0 is held at zero permanently
   logic [LEN-1:0] rf_reg [0:NREG-1];

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_rf
         // One register-file entry: cleared on reset, written by write-back
         always_ff @(posedge i_clk) begin
            if (i_rst || (gi == 0)) begin
               rf_reg[gi] <= '0;
            end else if (i_RegWrite && (i_write_reg == NB_ADDR'(gi))) begin
               rf_reg[gi] <= i_write_data;
            end
         end
      end
   endgenerate

`ifdef ID_DEBUG_READ_EN
   assign o_debug_reg_data = rf_reg[i_debug_reg_addr];
`endif

   logic [LEN-1:0] read_data_1;
   logic [LEN-1:0] read_data_2;

   // Combinational register reads, forwarding a same-cycle write-back
   always_comb begin
      read_data_1 = rf_reg[rs];
      read_data_2 = rf_reg[rt];
      if (rs == '0) begin
         read_data_1 = '0;
      end else if (i_RegWrite && (i_write_reg == rs)) begin
         read_data_1 = i_write_data;
      end
      if (rt == '0) begin
         read_data_2 = '0;
      end else if (i_RegWrite && (i_write_reg == rt)) begin
         read_data_2 = i_write_data;
      end
   end

   logic [5:0] ctrl_next;
   logic       uses_rs;
   logic       uses_rt;
   logic       is_beq;
   logic       is_bne;
   logic       is_j;
   logic       is_jr;
   logic       zero_ext;

   // Main control decode; unknown encodings leave every control bit low
   always_comb begin
      ctrl_next = '0;
      uses_rs   = 1'b0;
      uses_rt   = 1'b0;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      is_j      = 1'b0;
      is_jr     = 1'b0;
      zero_ext  = 1'b0;
      case (opcode)
         OP_R: begin
            case (funct)
               F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT: begin
                  ctrl_next = CTRL_R;
                  uses_rs   = 1'b1;
                  uses_rt   = 1'b1;
               end
               F_SLL, F_SRL, F_SRA: begin
                  ctrl_next = CTRL_R;
                  uses_rt   = 1'b1;
               end
               F_JR: begin
                  is_jr   = 1'b1;
                  uses_rs = 1'b1;
               end
               default: ;
            endcase
         end
         OP_LW: begin
            ctrl_next = CTRL_LW;
            uses_rs   = 1'b1;
         end
         OP_SW: begin
            ctrl_next = CTRL_SW;
            uses_rs   = 1'b1;
            uses_rt   = 1'b1;
         end
         OP_ADDI: begin
            ctrl_next = CTRL_I;
            uses_rs   = 1'b1;
         end
         OP_ANDI, OP_ORI: begin
            ctrl_next = CTRL_I;
            uses_rs   = 1'b1;
            zero_ext  = 1'b1;
         end
         OP_LUI: begin
            ctrl_next = CTRL_I;
         end
         OP_BEQ: begin
            is_beq  = 1'b1;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         OP_BNE: begin
            is_bne  = 1'b1;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         OP_J: begin
            is_j = 1'b1;
         end
         default: ;
      endcase
   end

   logic [LEN-1:0] sign_ext;
   assign sign_ext = zero_ext ? {{(LEN-16){1'b0}}, imm} : {{(LEN-16){imm[15]}}, imm};

   logic [NB_ADDR-1:0] ex_dest;
   logic               load_use;
   logic               branch_hazard;
   logic               stall;

   // Hazard detection: load-use for any consumer, plus unresolved producers for branch/JR operands
   always_comb begin
      ex_dest  = o_RegDst ? o_rd : o_rt;
      load_use = o_MemRead && (o_rt != '0) &&
                 ((uses_rs && (rs == o_rt)) || (uses_rt && (rt == o_rt)));
      branch_hazard = 1'b0;
      if (is_beq || is_bne || is_jr) begin
         if (uses_rs && (rs != '0) &&
             ((o_RegWrite && (rs == ex_dest)) || (i_mem_RegWrite && (rs == i_mem_write_reg)))) begin
            branch_hazard = 1'b1;
         end
         if (uses_rt && (rt != '0) &&
             ((o_RegWrite && (rt == ex_dest)) || (i_mem_RegWrite && (rt == i_mem_write_reg)))) begin
            branch_hazard = 1'b1;
         end
      end
      stall = load_use || branch_hazard;
   end

   // Fetch redirection; suppressed while the current instruction is stalled
   always_comb begin
      o_stall_flag  = stall;
      o_PC_branch   = i_PC + sign_ext;
      o_PCSrc       = ~stall && ((is_beq && (read_data_1 == read_data_2)) ||
                                 (is_bne && (read_data_1 != read_data_2)));
      o_jump        = ~stall && (is_j || is_jr);
      o_PC_dir_jump = is_jr ? read_data_1 : {i_PC[LEN-1:26], i_instruction[25:0]};
   end

   logic [LEN-1:0]     pc_reg;
   logic [LEN-1:0]     rd1_reg;
   logic [LEN-1:0]     rd2_reg;
   logic [LEN-1:0]     sext_reg;
   logic [NB_ADDR-1:0] rs_reg;
   logic [NB_ADDR-1:0] rt_reg;
   logic [NB_ADDR-1:0] rd_reg;
   logic [5:0]         opcode_reg;
   logic [5:0]         funct_reg;
   logic [5:0]         ctrl_reg;

   // ID/EX pipeline register; a stall inserts a bubble by clearing control
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_reg     <= '0;
         rd1_reg    <= '0;
         rd2_reg    <= '0;
         sext_reg   <= '0;
         rs_reg     <= '0;
         rt_reg     <= '0;
         rd_reg     <= '0;
         opcode_reg <= '0;
         funct_reg  <= '0;
         ctrl_reg   <= '0;
      end else begin
         pc_reg     <= i_PC;
         rd1_reg    <= read_data_1;
         rd2_reg    <= read_data_2;
         sext_reg   <= sign_ext;
         rs_reg     <= rs;
         rt_reg     <= rt;
         rd_reg     <= rd;
         opcode_reg <= opcode;
         funct_reg  <= funct;
         ctrl_reg   <= stall ? 6'b0 : ctrl_next;
      end
   end

   assign o_PC          = pc_reg;
   assign o_read_data_1 = rd1_reg;
   assign o_read_data_2 = rd2_reg;
   assign o_sign_ext    = sext_reg;
   assign o_rs          = rs_reg;
   assign o_rt          = rt_reg;
   assign o_rd          = rd_reg;
   assign o_opcode      = opcode_reg;
   assign o_funct       = funct_reg;
   assign o_RegWrite    = ctrl_reg[5];
   assign o_MemRead     = ctrl_reg[4];
   assign o_MemWrite    = ctrl_reg[3];
   assign o_MemtoReg    = ctrl_reg[2];
   assign o_RegDst      = ctrl_reg[1];
   assign o_ALUSrc      = ctrl_reg[0];

endmodule
